// File: rtl/imem_pkg.sv
// Shared constants for the synchronous instruction memory: MIPS encodings, FSM states, boot table.
// The boot image is used only when IMEM_BOOT_PROGRAM_EN is defined; otherwise INIT fills with NOPs.
package imem_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] OPR_ADD = 6'h20;
  localparam logic [5:0] OPR_SUB = 6'h22;

  localparam logic [4:0] R00 = 5'd0,  R01 = 5'd1,  R02 = 5'd2,  R03 = 5'd3;
  localparam logic [4:0] R04 = 5'd4,  R05 = 5'd5,  R06 = 5'd6,  R07 = 5'd7;
  localparam logic [4:0] R08 = 5'd8,  R09 = 5'd9,  R10 = 5'd10, R11 = 5'd11;
  localparam logic [4:0] R12 = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15;
  localparam logic [4:0] R16 = 5'd16, R17 = 5'd17, R18 = 5'd18, R19 = 5'd19;
  localparam logic [4:0] R20 = 5'd20, R21 = 5'd21, R22 = 5'd22, R23 = 5'd23;
  localparam logic [4:0] R24 = 5'd24, R25 = 5'd25, R26 = 5'd26, R27 = 5'd27;
  localparam logic [4:0] R28 = 5'd28, R29 = 5'd29, R30 = 5'd30, R31 = 5'd31;
  localparam logic [4:0] ZERO_SHAMT = 5'd0;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

`ifdef IMEM_BOOT_PROGRAM_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  // Init value for a word index: small boot loop in words 0..4, zero everywhere else.
  function automatic logic [31:0] boot_word(input int unsigned idx);
    logic [31:0] w_s;
    case (idx)
      32'd0:   w_s = {OP_ADDI, R00, R00, 16'd3};
      32'd1:   w_s = {OP_ADDI, R01, R01, 16'd4};
      32'd2:   w_s = {OP_R, R00, R01, R02, ZERO_SHAMT, OPR_ADD};
      32'd3:   w_s = {OP_R, R00, R01, R03, ZERO_SHAMT, OPR_ADD};
      32'd4:   w_s = {OP_J, 26'd1};
      default: w_s = 32'h0000_0000;
    endcase
    return BOOT_EN ? w_s : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/imem_init_seq.sv
// Post-reset fill sequencer: walks every word index once in INIT, then parks in RUN.
// Init contents come from imem_pkg::boot_word (boot image only with IMEM_BOOT_PROGRAM_EN).
module imem_init_seq
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we,
  output logic [IDX_W-1:0]  init_idx,
  output logic [DATA_W-1:0] init_data,
  output logic              busy
);

  imem_state_e      state_r, state_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: the last index is written on the edge that also enters RUN.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      INIT: begin
        if (cnt_r == IDX_W'(DEPTH - 1)) begin
          state_s = RUN;
        end else begin
          cnt_s = cnt_r + IDX_W'(1);
        end
      end
      RUN:     state_s = RUN;
      default: state_s = INIT;
    endcase
  end

  assign init_we   = (state_r == INIT);
  assign busy      = (state_r == INIT);
  assign init_idx  = cnt_r;
  assign init_data = DATA_W'(boot_word(32'(cnt_r)));

endmodule

// File: rtl/instruction_memory_sync.sv
// Clocked instruction memory: 1-cycle registered fetch with fault flagging, run-time load port.
// Array is filled by imem_init_seq after reset; IMEM_BOOT_PROGRAM_EN selects a boot image.
module instruction_memory_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W - 2)'(DEPTH);

  logic              init_we_s;
  logic [IDX_W-1:0]  init_idx_s;
  logic [DATA_W-1:0] init_data_s;
  logic              busy_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              fetch_valid_r, fetch_fault_r, load_err_r;
  logic [DATA_W-1:0] fetch_instr_r;

  imem_init_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_we   (init_we_s),
    .init_idx  (init_idx_s),
    .init_data (init_data_s),
    .busy      (busy_s)
  );

  // Range is checked on the full word index so high address bits cannot alias into the array.
  logic [ADDR_W-3:0] fetch_word_s, load_word_s;
  logic              fetch_bad_s, load_bad_s, fetch_acc_s, load_ok_s;

  assign fetch_word_s = fetch_addr[ADDR_W-1:2];
  assign load_word_s  = load_addr[ADDR_W-1:2];
  assign fetch_bad_s  = (fetch_addr[1:0] != 2'b00) || (fetch_word_s >= DEPTH_W);
  assign load_bad_s   = (load_addr[1:0] != 2'b00) || (load_word_s >= DEPTH_W);
  assign fetch_acc_s  = fetch_req && !busy_s;
  assign load_ok_s    = load_we && !busy_s && !load_bad_s;

  // Array write port: init sequencer owns it during INIT, load port afterwards.
  always_ff @(posedge clk) begin
    if (init_we_s) begin
      mem_r[init_idx_s] <= init_data_s;
    end else if (load_ok_s) begin
      mem_r[load_word_s[IDX_W-1:0]] <= load_data;
    end
  end

  // Registered fetch response; same-edge load is not visible (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_r <= 1'b0;
      fetch_instr_r <= {DATA_W{1'b0}};
      fetch_fault_r <= 1'b0;
      load_err_r    <= 1'b0;
    end else begin
      fetch_valid_r <= fetch_acc_s;
      load_err_r    <= load_we && (busy_s || load_bad_s);
      if (fetch_acc_s) begin
        fetch_fault_r <= fetch_bad_s;
        fetch_instr_r <= fetch_bad_s ? {DATA_W{1'b0}} : mem_r[fetch_word_s[IDX_W-1:0]];
      end
    end
  end

  assign fetch_valid = fetch_valid_r;
  assign fetch_instr = fetch_instr_r;
  assign fetch_fault = fetch_fault_r;
  assign load_err    = load_err_r;
  assign busy        = busy_s;
  assign fetch_ready = !busy_s;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed scoreboard bench for instruction_memory_sync (DEPTH=16); expected init contents
// follow IMEM_BOOT_PROGRAM_EN when the bench is built with it.
module tb_instruction_memory_sync;

  localparam int DEPTH = 16;

`ifdef IMEM_BOOT_PROGRAM_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_instr;
  logic        load_we;
  logic [31:0] load_addr, load_data;
  logic        load_err, busy;

  instruction_memory_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[DEPTH];
  int          init_left;
  logic        lerr_exp;
  logic [31:0] last_instr;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] tbl[5];
    tbl[0] = 32'h2000_0003;
    tbl[1] = 32'h2021_0004;
    tbl[2] = 32'h0001_1020;
    tbl[3] = 32'h0001_1820;
    tbl[4] = 32'h0800_0001;
    return (BOOT_EN && i < 5) ? tbl[i] : 32'h0000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (init_left > 0) init_left--;
    chk({tag, "/ready"}, {31'd0, fetch_ready}, {31'd0, init_left == 0});
    chk({tag, "/busy"}, {31'd0, busy}, {31'd0, init_left != 0});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "/valid"}, {31'd0, fetch_valid}, 32'd1);
      chk({tag, "/instr"}, fetch_instr, e.instr);
      chk({tag, "/fault"}, {31'd0, fetch_fault}, {31'd0, e.fault});
      last_instr = e.instr;
    end else begin
      chk({tag, "/novalid"}, {31'd0, fetch_valid}, 32'd0);
      chk({tag, "/hold"}, fetch_instr, last_instr);
    end
    chk({tag, "/load_err"}, {31'd0, load_err}, {31'd0, lerr_exp});
  endtask

  // Drive one cycle of stimulus; expectations use the model before this cycle's write.
  task automatic drive(input string tag, input logic req, input logic [31:0] addr,
                       input logic we, input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    fetch_req  = req;
    fetch_addr = addr;
    load_we    = we;
    load_addr  = la;
    load_data  = ld;
    if (req && init_left == 0) begin
      e.fault = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd16);
      e.instr = e.fault ? 32'h0000_0000 : model[addr[5:2]];
      exp_q.push_back(e);
    end
    lerr_exp = we && (init_left != 0 || la[1:0] != 2'b00 || la[31:2] >= 30'd16);
    if (we && !lerr_exp) model[la[5:2]] = ld;
    tick(tag);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr);
    drive(tag, 1'b1, addr, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input string tag, input logic [31:0] la, input logic [31:0] ld);
    drive(tag, 1'b0, 32'h0, 1'b1, la, ld);
  endtask

  // Hold reset across two edges (fetch_req left as-is so an in-flight request must be dropped).
  task automatic do_reset();
    rst_n    = 1'b0;
    load_we  = 1'b0;
    lerr_exp = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst/instr", fetch_instr, 32'h0000_0000);
    chk("rst/fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst/load_err", {31'd0, load_err}, 32'd0);
    chk("rst/ready", {31'd0, fetch_ready}, 32'd0);
    chk("rst/busy", {31'd0, busy}, 32'd1);
    fetch_req  = 1'b0;
    rst_n      = 1'b1;
    init_left  = DEPTH;
    last_instr = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) model[i] = init_val(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    load_we    = 1'b0;
    load_addr  = 32'h0;
    load_data  = 32'h0;
    do_reset();

    // INIT: requests ignored, loads rejected at the first and last INIT edge
    for (int i = 0; i < DEPTH; i++)
      drive("init", 1'b1, 32'h0, (i == 0) || (i == DEPTH - 1), 32'h8, 32'hBAD0_BAD0);

    fetch("first", 32'h0);
    fetch("boot0", 32'h0);
    fetch("boot1", 32'h4);
    fetch("boot2", 32'h8);
    fetch("boot3", 32'hC);
    fetch("boot4", 32'h10);
    fetch("boot5", 32'h14);
    drive("idle0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    fetch("mis6", 32'h6);
    fetch("oor40", 32'h40);
    fetch("last3c", 32'h3C);
    fetch("oorhigh", 32'hFFFF_FFFC);
    load("ld_mis41", 32'h41, 32'hCAFE_0001);
    load("ld_oor40", 32'h40, 32'hCAFE_0002);
    load("ld_mis3e", 32'h3E, 32'hCAFE_0003);
    fetch("chk0", 32'h0);
    fetch("chk3c", 32'h3C);

    load("ld8", 32'h8, 32'hDEAD_BEEF);
    fetch("rd8", 32'h8);
    drive("rbw", 1'b1, 32'hC, 1'b1, 32'hC, 32'h1234_5678);
    fetch("rdc", 32'hC);
    drive("ldlast", 1'b1, 32'h3C, 1'b1, 32'h3C, 32'hA5A5_A5A5);
    fetch("rdlast", 32'h3C);
    drive("idle1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset while a fetch is in flight; INIT reruns and overwrites loaded words
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    #3;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      drive("reinit", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch("post8", 32'h8);
    fetch("postc", 32'hC);
    fetch("post3c", 32'h3C);
    drive("idle2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
Name: instruction_memory_sync

Overview:
Parametrised, clocked instruction memory for the MIPS core that replaces the purely combinational ROM. Has a fetch port with a one-cycle registered read and a req/valid handshake, plus a program-load write port so software images can be written at run time. After reset, an initialisation sequencer fills the array before fetches are accepted. Misaligned and out-of-range fetches are flagged rather than silently returning zero.

Parameters:
DATA_W, 32, instruction word width in bits.
ADDR_W, 32, byte-address width of the fetch and load ports.
DEPTH, 256, number of words in the array; not required to be a power of two; must be ≥ 8.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request; sampled only when fetch_ready=1
fetch_addr  in  ADDR_W  byte address of the instruction
fetch_ready  out  1  high when the block accepts fetches; low during init
fetch_valid  out  1  one-cycle pulse: fetch_instr/fetch_fault are valid
fetch_instr  out  DATA_W  fetched word; 0 on fault
fetch_fault  out  1  fault on this response: misaligned or out of range
load_we  in  1  program-load write strobe
load_addr  in  ADDR_W  byte address for the write
load_data  in  DATA_W  word to write
load_err  out  1  one-cycle pulse: previous write was dropped
busy  out  1  high while the init sequencer runs

Behaviour:
- Reset (rst_n low, asynchronous): fetch_valid=0, fetch_instr=0, fetch_fault=0, load_err=0, fetch_ready=0, busy=1. FSM forced to INIT, init counter forced to 0. A reset asserted mid-operation aborts any response in flight; no fetch_valid is emitted for that response.
- FSM states:
  - INIT: writes word[cnt] = init value, cnt += 1 each cycle. When cnt reaches DEPTH-1, the FSM moves to RUN on the next edge. INIT lasts exactly DEPTH cycles after rst_n deasserts.
  - RUN: fetch_ready=1, busy=0. RUN is terminal until the next reset.
- Fetch handshake:
  - A request is accepted on an edge where fetch_req=1 and fetch_ready=1.
  - The response appears on the next edge: fetch_valid=1 for exactly one cycle, with fetch_instr and fetch_fault.
  - Back-to-back requests are accepted every cycle (throughput 1 per clock). There is no consumer backpressure.
  - fetch_req during INIT is ignored and produces no response.
- Address checks, word index = fetch_addr >> 2:
  - fetch_addr[1:0] != 0 → fault=1, instr=0.
  - index ≥ DEPTH → fault=1, instr=0.
  - Otherwise fault=0, instr=word[index].
- Load port:
  - Accepted only in RUN. load_we during INIT is dropped and load_err pulses on the next cycle.
  - A misaligned or out-of-range load is dropped and load_err pulses on the next cycle.
  - A valid write updates word[index] at the edge.
- Simultaneous fetch and load to the same word on the same edge: the fetch returns the OLD contents (read-before-write). The new value is visible from the next fetch onward.
- fetch_instr holds its last value between valid pulses; consumers qualify it with fetch_valid.

Optional Feature:
Macro IMEM_BOOT_PROGRAM_EN.
- Defined: INIT writes the boot table into words 0..4 and 0 elsewhere. Boot table:
  - word 0 = 0x20000003 (addi $0,$0,3)
  - word 1 = 0x20210004 (addi $1,$1,4)
  - word 2 = 0x00011020 (add $2,$0,$1)
  - word 3 = 0x00011820 (add $3,$0,$1)
  - word 4 = 0x08000001 (j 1)
- Not defined: INIT writes 0 (NOP) to every word, and a program must be loaded through the load port before it is useful.
- INIT length is DEPTH cycles in both cases.

Decomposition:
- Shared package imem_pkg:
  - opcode constants (OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J) and funct constants (OPR_ADD, OPR_SUB);
  - register-number constants R00..R31 and ZERO_SHAMT;
  - FSM state encoding (INIT, RUN);
  - boot-table function mapping word index → init word.
- One sub-module, imem_init_seq: counter plus INIT/RUN FSM. Outputs init_we, init_idx, init_data, busy. The top module muxes init writes versus load writes into the array.

Test Plan:
- Init timing, DEPTH=16, macro undefined: release rst_n → busy=1 and fetch_ready=0 for exactly 16 cycles; fetch_ready=1 on cycle 17; fetch of 0x0 → fetch_valid next cycle, instr=0x00000000, fault=0.
- Boot content, macro defined: after init, fetch 0x0, 0x4, 0x8, 0xC, 0x10 back-to-back → five consecutive valid pulses returning 0x20000003, 0x20210004, 0x00011020, 0x00011820, 0x08000001; fetch 0x14 → 0.
- Faults, DEPTH=16: fetch 0x6 → fault=1, instr=0; fetch 0x40 → fault=1, instr=0; load to 0x41 → load_err pulse, array unchanged.
- Load path: load 0xDEADBEEF to 0x8 → next fetch 0x8 returns 0xDEADBEEF. Same-edge load 0x12345678 to 0xC with fetch 0xC → response is the old value; a second fetch returns 0x12345678.
- Reset mid-operation: issue fetch, assert rst_n low before the response edge → no fetch_valid; after release, INIT reruns (busy=1 for DEPTH cycles) and loaded data is overwritten with init values.
- Fetch during INIT: fetch_req=1 throughout INIT → no fetch_valid; load_we during INIT → load_err pulse.
